dbus_arbiter: RTL and testbench

//   Two-master arbiter sharing the single data-bus slave port (on-chip RAM + peripherals)

---
 rtl/dbus_arbiter_if.sv | 32 +++
 rtl/dbus_arbiter.sv | 139 +++++++++++++
 tb/tb_dbus_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dbus_arbiter_if
//  Description : One data-bus link (command + read response) between a
//                master and a slave. Used for both arbiter-facing masters
//                and the shared slave port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dbus_arbiter_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [31:0] cmd_address;
    logic [31:0] cmd_data;
    logic [1:0]  cmd_size;
    logic        rsp_ready;
    logic        rsp_error;
    logic [31:0] rsp_data;

    // Issuer of commands, receiver of responses
    modport master (
        output cmd_valid, cmd_wr, cmd_address, cmd_data, cmd_size,
        input  cmd_ready, rsp_ready, rsp_error, rsp_data
    );

    // Acceptor of commands, producer of responses
    modport slave (
        input  cmd_valid, cmd_wr, cmd_address, cmd_data, cmd_size,
        output cmd_ready, rsp_ready, rsp_error, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/dbus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dbus_arbiter
//  Description : Two-master data-bus arbiter. Fixed priority to m0 with a
//                starvation counter guaranteeing m1 progress, grant lock while
//                a command is stalled, and per-cycle read response routing.
//  Revision    : 1.0 - initial release
// ============================================================================
module dbus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_BITS     = 8
) (
    input  wire logic     clk,
    input  wire logic     reset,
    dbus_arbiter_if.slave  m0,
    dbus_arbiter_if.slave  m1,
    dbus_arbiter_if.master s,
    output logic          unexpected_rsp
);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_HOLD0 = 2'd1,
        ST_HOLD1 = 2'd2
    } state_t;

    localparam logic [CNT_BITS-1:0] c_starve_limit = CNT_BITS'(STARVE_LIMIT);
    localparam logic [CNT_BITS-1:0] c_cnt_max      = '1;

    state_t              r_state;
    logic [CNT_BITS-1:0] r_starve_cnt;
    logic                r_rd_pend;
    logic                r_rd_owner;
    logic                r_unexpected_rsp;

    logic w_m1_wins;
    logic w_gnt_valid;
    logic w_gnt_sel;
    logic w_active;
    logic w_xfer;
    logic w_m1_xfer;
    logic w_gnt_wr;
    logic w_rsp_live;

    assign w_m1_wins = m1.cmd_valid && (!m0.cmd_valid || (r_starve_cnt >= c_starve_limit));

    // Grant selection: free arbitration in ARB, locked to the stalled master in HOLDn
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_sel   = 1'b0;
        case (r_state)
            ST_HOLD0: begin
                w_gnt_valid = 1'b1;
                w_gnt_sel   = 1'b0;
            end
            ST_HOLD1: begin
                w_gnt_valid = 1'b1;
                w_gnt_sel   = 1'b1;
            end
            default: begin
                w_gnt_valid = m0.cmd_valid || m1.cmd_valid;
                w_gnt_sel   = w_m1_wins;
            end
        endcase
    end

    // Nothing is offered or accepted while reset is held
    assign w_active  = w_gnt_valid && !reset;
    assign w_xfer    = w_active && s.cmd_ready;
    assign w_m1_xfer = w_xfer && w_gnt_sel;
    assign w_gnt_wr  = w_gnt_sel ? m1.cmd_wr : m0.cmd_wr;

    assign s.cmd_valid   = w_active;
    assign s.cmd_wr      = w_gnt_wr;
    assign s.cmd_address = w_gnt_sel ? m1.cmd_address : m0.cmd_address;
    assign s.cmd_data    = w_gnt_sel ? m1.cmd_data    : m0.cmd_data;
    assign s.cmd_size    = w_gnt_sel ? m1.cmd_size    : m0.cmd_size;

    assign m0.cmd_ready  = w_active && !w_gnt_sel && s.cmd_ready;
    assign m1.cmd_ready  = w_active &&  w_gnt_sel && s.cmd_ready;

    // Response goes only to the master whose read was accepted last cycle
    assign w_rsp_live    = !reset && r_rd_pend && s.rsp_ready;
    assign m0.rsp_ready  = w_rsp_live && !r_rd_owner;
    assign m1.rsp_ready  = w_rsp_live &&  r_rd_owner;
    assign m0.rsp_data   = s.rsp_data;
    assign m1.rsp_data   = s.rsp_data;
    assign m0.rsp_error  = s.rsp_error;
    assign m1.rsp_error  = s.rsp_error;

    assign unexpected_rsp = r_unexpected_rsp;

    // Grant-lock FSM: a stalled command keeps the bus until the slave takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_ARB;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_gnt_valid && !s.cmd_ready)
                        r_state <= w_gnt_sel ? ST_HOLD1 : ST_HOLD0;
                end
                ST_HOLD0, ST_HOLD1: begin
                    if (s.cmd_ready)
                        r_state <= ST_ARB;
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    // Starvation counter: counts cycles m1 waits, saturating, cleared when m1 is served or idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (m1.cmd_valid && !w_m1_xfer) begin
            if (r_starve_cnt != c_cnt_max)
                r_starve_cnt <= r_starve_cnt + 1'b1;
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // Read tracking: remember owner of the read accepted this cycle; flag stray responses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pend        <= 1'b0;
            r_rd_owner       <= 1'b0;
            r_unexpected_rsp <= 1'b0;
        end else begin
            r_rd_pend  <= w_xfer && !w_gnt_wr;
            r_rd_owner <= w_gnt_sel;
            if (s.rsp_ready && !r_rd_pend)
                r_unexpected_rsp <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dbus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dbus_arbiter
//  Description : Directed self-checking bench for dbus_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dbus_arbiter;

    logic clk;
    logic reset;
    logic unexpected_rsp;

    int n_checks;
    int n_errors;

    dbus_arbiter_if m0_bus ();
    dbus_arbiter_if m1_bus ();
    dbus_arbiter_if s_bus  ();

    dbus_arbiter #(
        .STARVE_LIMIT (4),
        .CNT_BITS     (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .m0             (m0_bus.slave),
        .m1             (m1_bus.slave),
        .s              (s_bus.master),
        .unexpected_rsp (unexpected_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and move away from the edge before driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m0(input logic v, input logic wr, input logic [31:0] a);
        m0_bus.cmd_valid = v; m0_bus.cmd_wr = wr; m0_bus.cmd_address = a;
        m0_bus.cmd_data = a ^ 32'hA5A5_0000; m0_bus.cmd_size = 2'd2;
    endtask

    task automatic drive_m1(input logic v, input logic wr, input logic [31:0] a);
        m1_bus.cmd_valid = v; m1_bus.cmd_wr = wr; m1_bus.cmd_address = a;
        m1_bus.cmd_data = a ^ 32'h5A5A_0000; m1_bus.cmd_size = 2'd2;
    endtask

    task automatic drive_s(input logic cr, input logic rr, input logic [31:0] d);
        s_bus.cmd_ready = cr; s_bus.rsp_ready = rr; s_bus.rsp_data = d; s_bus.rsp_error = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        drive_m0(1'b1, 1'b0, 32'h0000_0100);
        drive_m1(1'b1, 1'b0, 32'h0000_0200);
        drive_s(1'b1, 1'b1, 32'h0);

        // Reset: all handshakes held low even with requests present
        tick();
        tick();
        #1;
        check("rst_s_valid",   32'(s_bus.cmd_valid),  32'd0);
        check("rst_m0_ready",  32'(m0_bus.cmd_ready), 32'd0);
        check("rst_m1_ready",  32'(m1_bus.cmd_ready), 32'd0);
        check("rst_m0_rsp",    32'(m0_bus.rsp_ready), 32'd0);
        check("rst_unexp",     32'(unexpected_rsp),   32'd0);

        // Test 1: m0 read, response next cycle
        tick();
        reset = 1'b0;
        drive_m1(1'b0, 1'b0, 32'h0);
        drive_s(1'b1, 1'b0, 32'h0);
        #1;
        check("t1_m0_ready",  32'(m0_bus.cmd_ready), 32'd1);
        check("t1_s_valid",   32'(s_bus.cmd_valid),  32'd1);
        check("t1_s_addr",    s_bus.cmd_address,     32'h0000_0100);
        tick();
        drive_m0(1'b0, 1'b0, 32'h0);
        drive_s(1'b1, 1'b1, 32'hDEAD_BEEF);
        #1;
        check("t1_m0_rsp",    32'(m0_bus.rsp_ready), 32'd1);
        check("t1_m0_data",   m0_bus.rsp_data,       32'hDEAD_BEEF);
        check("t1_m1_rsp",    32'(m1_bus.rsp_ready), 32'd0);

        // Test 2: both masters always valid, m1 wins every 5th grant
        tick();
        drive_s(1'b1, 1'b0, 32'h0);
        drive_m0(1'b1, 1'b1, 32'h0000_1000);
        drive_m1(1'b1, 1'b1, 32'h0000_2000);
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("t2_m1_ready_%0d", i), 32'(m1_bus.cmd_ready), (i % 5 == 4) ? 32'd1 : 32'd0);
            check($sformatf("t2_m0_ready_%0d", i), 32'(m0_bus.cmd_ready), (i % 5 == 4) ? 32'd0 : 32'd1);
            tick();
        end

        // Test 3: m1 stalled in HOLD1 while m0 requests
        drive_m0(1'b0, 1'b0, 32'h0);
        drive_m1(1'b1, 1'b1, 32'h0000_0300);
        drive_s(1'b0, 1'b0, 32'h0);
        #1;
        check("t3_m1_ready_c1", 32'(m1_bus.cmd_ready), 32'd0);
        tick();
        drive_m0(1'b1, 1'b1, 32'h0000_0400);
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("t3_state_%0d", i), 32'(dut.r_state),  32'd2);
            check($sformatf("t3_addr_%0d", i),  s_bus.cmd_address, 32'h0000_0300);
            check($sformatf("t3_m0_rdy_%0d", i), 32'(m0_bus.cmd_ready), 32'd0);
            tick();
        end
        drive_s(1'b1, 1'b0, 32'h0);
        #1;
        check("t3_m1_accept", 32'(m1_bus.cmd_ready), 32'd1);
        check("t3_m0_block",  32'(m0_bus.cmd_ready), 32'd0);
        tick();
        drive_m0(1'b0, 1'b0, 32'h0);
        drive_m1(1'b0, 1'b0, 32'h0);
        #1;
        check("t3_back_arb", 32'(dut.r_state), 32'd0);

        // Test 4: alternating back-to-back reads
        tick();
        drive_m0(1'b1, 1'b0, 32'h0000_0000);
        #1;
        check("t4_m0_acc0", 32'(m0_bus.cmd_ready), 32'd1);
        tick();
        drive_m0(1'b0, 1'b0, 32'h0);
        drive_m1(1'b1, 1'b0, 32'h0000_0004);
        drive_s(1'b1, 1'b1, 32'h1111_1111);
        #1;
        check("t4_m1_acc",   32'(m1_bus.cmd_ready), 32'd1);
        check("t4_r0_m0",    32'(m0_bus.rsp_ready), 32'd1);
        check("t4_r0_m1",    32'(m1_bus.rsp_ready), 32'd0);
        check("t4_r0_data",  m0_bus.rsp_data,       32'h1111_1111);
        tick();
        drive_m1(1'b0, 1'b0, 32'h0);
        drive_m0(1'b1, 1'b0, 32'h0000_0008);
        drive_s(1'b1, 1'b1, 32'h2222_2222);
        #1;
        check("t4_m0_acc8",  32'(m0_bus.cmd_ready), 32'd1);
        check("t4_r1_m1",    32'(m1_bus.rsp_ready), 32'd1);
        check("t4_r1_m0",    32'(m0_bus.rsp_ready), 32'd0);
        check("t4_r1_data",  m1_bus.rsp_data,       32'h2222_2222);
        tick();
        drive_m0(1'b0, 1'b0, 32'h0);
        drive_s(1'b1, 1'b1, 32'h3333_3333);
        #1;
        check("t4_r2_m0",    32'(m0_bus.rsp_ready), 32'd1);
        check("t4_r2_m1",    32'(m1_bus.rsp_ready), 32'd0);
        check("t4_r2_data",  m0_bus.rsp_data,       32'h3333_3333);
        check("t4_no_unexp", 32'(unexpected_rsp),   32'd0);

        // Test 5: m1 write, then a stray response
        tick();
        drive_s(1'b1, 1'b0, 32'h0);
        drive_m1(1'b1, 1'b1, 32'h0000_0500);
        #1;
        check("t5_m1_wr_acc", 32'(m1_bus.cmd_ready), 32'd1);
        tick();
        drive_m1(1'b0, 1'b0, 32'h0);
        drive_s(1'b1, 1'b1, 32'h4444_4444);
        #1;
        check("t5_m0_rsp", 32'(m0_bus.rsp_ready), 32'd0);
        check("t5_m1_rsp", 32'(m1_bus.rsp_ready), 32'd0);
        tick();
        drive_s(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t5_unexp_%0d", i), 32'(unexpected_rsp), 32'd1);
            tick();
        end

        // Test 6: reset during HOLD0 with a read response in flight
        drive_m0(1'b1, 1'b0, 32'h0000_0600);
        #1;
        check("t6_m0_acc", 32'(m0_bus.cmd_ready), 32'd1);
        tick();
        drive_m0(1'b1, 1'b0, 32'h0000_0604);
        drive_s(1'b0, 1'b0, 32'h0);
        #1;
        check("t6_pend", 32'(dut.r_rd_pend), 32'd1);
        tick();
        drive_m1(1'b1, 1'b0, 32'h0000_0700);
        #1;
        check("t6_hold0", 32'(dut.r_state), 32'd1);
        check("t6_cnt_run", 32'(dut.r_starve_cnt), 32'd0);
        tick();
        #1;
        check("t6_cnt_one", 32'(dut.r_starve_cnt), 32'd1);
        reset = 1'b1;
        drive_s(1'b1, 1'b1, 32'h5555_5555);
        #1;
        check("t6_rst_svalid", 32'(s_bus.cmd_valid),  32'd0);
        check("t6_rst_m0rdy",  32'(m0_bus.cmd_ready), 32'd0);
        check("t6_rst_m1rdy",  32'(m1_bus.cmd_ready), 32'd0);
        check("t6_rst_m0rsp",  32'(m0_bus.rsp_ready), 32'd0);
        check("t6_rst_m1rsp",  32'(m1_bus.rsp_ready), 32'd0);
        tick();
        reset = 1'b0;
        drive_m0(1'b0, 1'b0, 32'h0);
        drive_m1(1'b0, 1'b0, 32'h0);
        drive_s(1'b1, 1'b0, 32'h0);
        #1;
        check("t6_state",   32'(dut.r_state),      32'd0);
        check("t6_cnt",     32'(dut.r_starve_cnt), 32'd0);
        check("t6_rd_pend", 32'(dut.r_rd_pend),    32'd0);
        check("t6_unexp",   32'(unexpected_rsp),   32'd0);
        check("t6_svalid",  32'(s_bus.cmd_valid),  32'd0);
        check("t6_m0rsp",   32'(m0_bus.rsp_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Watchdog so the run always ends on its own
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
